// File: rtl/sata_rxfis_buffer.sv
// SATA transport-side RX FIS buffer: stores link words speculatively and
// releases a FIS to the output only after its last word arrives without abort.
module sata_rxfis_buffer #(
    parameter int unsigned LGFIFO            = 11,
    parameter int unsigned HEADROOM          = 16,
    parameter bit          OPT_LITTLE_ENDIAN = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        s_abort,
    output logic        o_full,
    output logic        o_empty,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [7:0]  m_fis_type,
    output logic        o_overflow,
    output logic        o_dropped
);
    localparam int unsigned   PW         = LGFIFO + 1;
    localparam int unsigned   DEPTH      = 1 << LGFIFO;
    localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH - HEADROOM);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RECV    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [32:0]   mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fill_c;
    logic          space_c;
    logic          mem_we_c;
    logic          overflow_q, overflow_d;
    logic          dropped_q, dropped_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    logic          load_c;
    logic [32:0]   rd_word_c;
    logic [7:0]    rd_type_c;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic [7:0]    fis_type_q, fis_type_d;
    logic          first_q, first_d;

    // Occupancy seen by the writer; reads in the current cycle are not credited.
    assign fill_c  = wr_ptr_q - rd_ptr_q;
    assign space_c = ~fill_c[LGFIFO];

    // Write FSM: speculative writes, commit on last, roll back on abort/overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we_c     = 1'b0;
        overflow_d   = 1'b0;
        dropped_d    = 1'b0;
        case (state_q)
            S_IDLE, S_RECV: begin
                if (s_abort && (state_q == S_RECV)) begin
                    wr_ptr_d  = commit_ptr_q;
                    dropped_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (s_valid) begin
                    if (space_c) begin
                        mem_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (s_last) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            state_d      = S_IDLE;
                        end else begin
                            state_d = S_RECV;
                        end
                    end else begin
                        wr_ptr_d   = commit_ptr_q;
                        overflow_d = 1'b1;
                        dropped_d  = 1'b1;
                        state_d    = s_last ? S_IDLE : S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if ((s_valid && s_last) || s_abort) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: load the next committed word when empty or being taken.
    always_comb begin
        rd_word_c  = mem[rd_ptr_q[LGFIFO-1:0]];
        rd_type_c  = OPT_LITTLE_ENDIAN ? rd_word_c[7:0] : rd_word_c[31:24];
        load_c     = (rd_ptr_q != commit_ptr_q) && (!m_valid_q || m_ready);
        rd_ptr_d   = rd_ptr_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        fis_type_d = fis_type_q;
        first_d    = first_q;
        if (load_c) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            m_valid_d = 1'b1;
            m_data_d  = rd_word_c[31:0];
            m_last_d  = rd_word_c[32];
            first_d   = rd_word_c[32];
            if (first_q) begin
                fis_type_d = rd_type_c;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Link flow control, derived from the registered pointers.
    always_comb begin
        full_d  = fill_c >= FULL_LEVEL;
        empty_d = (commit_ptr_q == rd_ptr_q) && !m_valid_q;
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            fis_type_q   <= '0;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            fis_type_q   <= fis_type_d;
            first_q      <= first_d;
        end
    end

    // Word storage {last, data}; no reset needed.
    always_ff @(posedge i_clk) begin
        if (mem_we_c) begin
            mem[wr_ptr_q[LGFIFO-1:0]] <= {s_last, s_data};
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_overflow = overflow_q;
    assign o_dropped  = dropped_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign m_fis_type = fis_type_q;

endmodule

// File: tb/tb_sata_rxfis_buffer.sv
// Self-checking bench for sata_rxfis_buffer: directed scenarios plus random
// FIS traffic checked against a committed-word scoreboard.
module tb_sata_rxfis_buffer;
    localparam int unsigned LGF = 4;
    localparam int unsigned HR  = 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_abort = 1'b0;
    logic        m_ready = 1'b0;
    logic        o_full, o_empty, m_valid, m_last, o_overflow, o_dropped;
    logic [31:0] m_data;
    logic [7:0]  m_fis_type;

    logic [1:0]  rdy_mode = 2'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          drop_cnt = 0;
    int          ovf_cnt  = 0;
    int          exp_drop = 0;
    int          exp_ovf  = 0;
    // Expected output words, in order: {type, last, data}
    logic [40:0] sb[$];

    always #5 clk = ~clk;

    sata_rxfis_buffer #(
        .LGFIFO(LGF), .HEADROOM(HR), .OPT_LITTLE_ENDIAN(1'b0)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_abort(s_abort),
        .o_full(o_full), .o_empty(o_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_fis_type(m_fis_type), .o_overflow(o_overflow), .o_dropped(o_dropped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Consumer ready: 0 = low, 1 = high, otherwise random each cycle
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            2'd0:    m_ready = 1'b0;
            2'd1:    m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: every accepted word must be the next committed word
    always @(negedge clk) begin
        logic [40:0] e;
        if (!i_reset) begin
            if (o_dropped)  drop_cnt++;
            if (o_overflow) ovf_cnt++;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_word", 32'(m_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", m_data, e[31:0]);
                    check("out_last", 32'(m_last), 32'(e[32]));
                    check("out_fis_type", 32'(m_fis_type), 32'(e[40:33]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_push(input logic [31:0] d, input logic l);
        sb.push_back({d[31:24], l, d});
        send(d, l);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_abort = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // One FIS; abort_at < 0 means no abort, otherwise abort before that word
    task automatic send_fis(input logic [7:0] typ, input int len, input int abort_at);
        logic [40:0] words[$];
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                s_abort = 1'b1;
                s_valid = 1'($urandom_range(0, 1));
                s_data  = $urandom;
                s_last  = 1'($urandom_range(0, 1));
                tick();
                s_abort = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                exp_drop++;
                return;
            end
            if ($urandom_range(0, 3) == 0) tick();
            d = {typ, 24'($urandom)};
            words.push_back({typ, (i == len - 1), d});
            send(d, (i == len - 1));
        end
        foreach (words[k]) sb.push_back(words[k]);
    endtask

    initial begin
        do_reset();
        // Reset state
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_fis_type", 32'(m_fis_type), 32'd0);
        check("rst_o_full", 32'(o_full), 32'd0);
        check("rst_o_empty", 32'(o_empty), 32'd1);
        check("rst_o_overflow", 32'(o_overflow), 32'd0);
        check("rst_o_dropped", 32'(o_dropped), 32'd0);

        // 5-word FIS, latency and type
        rdy_mode = 2'd1;
        tick();
        for (int i = 0; i < 5; i++) send_push(32'h27000000 + 32'(i), (i == 4));
        check("t1_valid_n1", 32'(m_valid), 32'd0);
        tick();
        check("t1_valid_n2", 32'(m_valid), 32'd1);
        check("t1_first_data", m_data, 32'h27000000);
        check("t1_fis_type", 32'(m_fis_type), 32'h27);
        drain(50);
        tick();
        tick();
        check("t1_empty", 32'(o_empty), 32'd1);

        // Abort after 3 words, then a clean 2-word FIS
        for (int i = 0; i < 3; i++) send(32'h11000000 + 32'(i), 1'b0);
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        exp_drop++;
        tick();
        tick();
        check("t2_drop_count", 32'(drop_cnt), 32'(exp_drop));
        check("t2_no_valid", 32'(m_valid), 32'd0);
        check("t2_empty", 32'(o_empty), 32'd1);
        send_push(32'h34000000, 1'b0);
        send_push(32'h34000001, 1'b1);
        drain(50);

        // o_full threshold (16 deep, 4 headroom -> 12 words)
        rdy_mode = 2'd0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 11) check("t3_full_before", 32'(o_full), 32'd0);
            send_push(32'h5A000000 + 32'(i), (i == 11));
        end
        check("t3_full_n1", 32'(o_full), 32'd0);
        tick();
        check("t3_full_n2", 32'(o_full), 32'd1);
        tick();
        check("t3_full_after_load", 32'(o_full), 32'd0);
        rdy_mode = 2'd1;
        drain(100);

        // Overflow on word 17 with a 1-word FIS held at the output
        rdy_mode = 2'd0;
        do_reset();
        send_push(32'h01000099, 1'b1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            send(32'h39000000 + 32'(i), (i == 19));
            if (i == 15) check("t4_no_ovf_16", 32'(o_overflow), 32'd0);
            if (i == 16) begin
                check("t4_ovf_17", 32'(o_overflow), 32'd1);
                check("t4_drop_17", 32'(o_dropped), 32'd1);
            end
            if (i == 17) check("t4_ovf_single", 32'(o_overflow), 32'd0);
        end
        exp_ovf++;
        exp_drop++;
        tick();
        tick();
        check("t4_ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
        rdy_mode = 2'd1;
        drain(100);
        tick();
        tick();
        check("t4_empty", 32'(o_empty), 32'd1);

        // Back-to-back FISes with random ready
        rdy_mode = 2'd2;
        do_reset();
        for (int i = 0; i < 4; i++) send_push(32'h46000000 + 32'(i), (i == 3));
        for (int i = 0; i < 3; i++) send_push(32'h5F000010 + 32'(i), (i == 2));
        drain(200);

        // Reset mid-FIS
        rdy_mode = 2'd0;
        tick();
        send(32'h77000000, 1'b0);
        send(32'h77000001, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_empty", 32'(o_empty), 32'd1);
        check("t6_full", 32'(o_full), 32'd0);
        rdy_mode = 2'd1;
        send_push(32'h27000100, 1'b0);
        send_push(32'h27000101, 1'b1);
        drain(50);

        // Random traffic, gated so the buffer never overflows
        rdy_mode = 2'd2;
        for (int f = 0; f < 60; f++) begin
            int len;
            int ab;
            int n;
            len = int'($urandom_range(1, 8));
            ab  = -1;
            if (len >= 2 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, len - 1));
            n = 0;
            while ((sb.size() + len > 15) && n < 500) begin
                tick();
                n++;
            end
            if (n >= 500) check("rand_space_timeout", 32'(sb.size()), 32'd0);
            send_fis(8'($urandom), len, ab);
        end
        drain(2000);
        tick();
        tick();
        check("final_drop_count", 32'(drop_cnt), 32'(exp_drop));
        check("final_ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
        check("final_empty", 32'(o_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
